// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM LED driver slice.
`timescale 1ns/1ps
package pwm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_PRESCALE = 4;

   // Pin level that leaves the LED dark for the given output polarity.
   function automatic logic inactive_level(input bit active_high);
      return !active_high;
   endfunction

endpackage

// File: rtl/pwm_driver_if.sv
// Duty-value handshake between the brightness ramp (master) and the PWM driver (slave).
`timescale 1ns/1ps
interface pwm_driver_if
   import pwm_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             duty_valid;
   logic [WIDTH-1:0] duty_data;
   logic             duty_ready;

   modport master (output duty_valid, output duty_data, input duty_ready);
   modport slave  (input duty_valid, input duty_data, output duty_ready);

endinterface

// File: rtl/pwm_prescaler.sv
// Divides the system clock into PWM ticks; clr holds the divider at zero.
`timescale 1ns/1ps
module pwm_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // Gated by clr so a PRESCALE of 1 does not tick while the block is idle.
   assign tick = !clr && (count == LAST);

endmodule

// File: rtl/pwm_driver.sv
// Single-channel PWM LED driver: shadow-buffered duty, applied only at period boundaries.
`timescale 1ns/1ps
module pwm_driver
   import pwm_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int PRESCALE    = DEF_PRESCALE,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   pwm_driver_if.slave      duty,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] duty_active
);

   localparam logic [WIDTH-1:0] CNT_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic             OFF_LEVEL = inactive_level(ACTIVE_HIGH);

   state_t           state, state_nxt;
   logic             pending;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] cnt;
   logic             tick, hold, wrap, boundary, boundary_q, accept, raw;

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (hold),
      .tick (tick)
   );

   assign duty.duty_ready = !pending;
   assign accept          = duty.duty_valid && !pending;
   assign wrap            = tick && (cnt == CNT_LAST);
   assign raw             = (cnt < duty_active);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      boundary  = 1'b0;
      hold      = 1'b1;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = RUN;
               boundary  = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_nxt = IDLE;
            end else begin
               hold     = 1'b0;
               boundary = wrap;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow data is cleared as well; pending alone marks it as holding a value.
         shadow       <= '0;
         pending      <= 1'b0;
         duty_active  <= '0;
         cnt          <= '0;
         boundary_q   <= 1'b0;
         period_start <= 1'b0;
         pwm_out      <= OFF_LEVEL;
      end else begin
         // A boundary consumes the shadow before any new offer; ready is low then, so no bypass.
         if (boundary && pending) begin
            duty_active <= shadow;
            pending     <= 1'b0;
         end else if (accept) begin
            shadow  <= duty.duty_data;
            pending <= 1'b1;
         end

         if (hold)      cnt <= '0;
         else if (tick) cnt <= wrap ? '0 : cnt + WIDTH'(1);

         // Compare output lags cnt by one clock, so period_start is delayed to stay aligned.
         boundary_q   <= boundary;
         period_start <= boundary_q && (state == RUN) && en;
         pwm_out      <= ((state == RUN) && en) ? ~(raw ^ ACTIVE_HIGH) : OFF_LEVEL;
      end
   end

endmodule
